// File: rtl/seg7_scan_sched.sv
// seg7_scan_sched
//   Produces the 6-bit display-select code that drives the seg7 channel
//   multiplexer. It sits between the board switches/buttons and the mux.
//   The mode input selects one of four behaviours:
//     MANUAL   - the switch code is passed straight through.
//     SCAN_CH  - steps through test channels 0..7, skipping masked-off ones.
//     SCAN_REG - steps through CPU registers 0..31.
//     HOLD     - freezes the display; single-stepping is still allowed.
//   In both scan modes each index is shown for DWELL clock cycles.
//
// Parameters
//   DWELL  cycles each channel/register is shown in the scan modes (>=2)
//   CNT_W  dwell counter width; must be able to hold DWELL-1
//
// Ports
//   clk        in  1  system clock, rising edge
//   rst        in  1  synchronous active-high reset
//   mode       in  2  00 MANUAL, 01 SCAN_CH, 10 SCAN_REG, 11 HOLD
//   sw_ctrl    in  6  switch select code, used in MANUAL
//   ch_mask    in  8  bit i set -> test channel i is part of the channel scan
//   step       in  1  single-cycle pulse: advance the index now
//   ctrl_out   out 6  registered select code to the seg7 multiplexer
//   dwell_tick out 1  registered 1-cycle pulse when a dwell expiry advances
//   scan_kind  out 1  0 = last scan was channels, 1 = registers
module seg7_scan_sched #(
  parameter int DWELL = 50_000_000,
  parameter int CNT_W = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic [5:0] sw_ctrl,
  input  logic [7:0] ch_mask,
  input  logic       step,
  output logic [5:0] ctrl_out,
  output logic       dwell_tick,
  output logic       scan_kind
);

  typedef enum logic [1:0] {
    MANUAL   = 2'b00,
    SCAN_CH  = 2'b01,
    SCAN_REG = 2'b10,
    HOLD     = 2'b11
  } state_t;

  state_t             state;
  state_t             mode_state;
  logic [2:0]         ch_idx;
  logic [4:0]         reg_idx;
  logic [CNT_W-1:0]   cnt;
  logic               came_from_manual;

  state_t             state_n;
  logic [2:0]         ch_n;
  logic [4:0]         reg_n;
  logic [CNT_W-1:0]   cnt_n;
  logic [5:0]         ctrl_n;
  logic               tick_n;
  logic               kind_n;
  logic               cfm_n;
  logic               expire;
  logic [2:0]         ch_first;
  logic [2:0]         ch_next;

  // Lowest enabled channel; 0 when nothing is enabled.
  function automatic logic [2:0] lowest_enabled(input logic [7:0] mask);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) r = 3'(i);
    end
    return r;
  endfunction

  // First enabled channel after idx, searching idx+1, idx+2, ... modulo 8.
  // Scanning from the farthest candidate down lets the nearest one win, and
  // the eighth candidate is idx itself, so a lone enabled channel stays put.
  // Returns 0 when nothing is enabled.
  function automatic logic [2:0] next_enabled(input logic [2:0] idx,
                                               input logic [7:0] mask);
    logic [2:0] r;
    logic [2:0] j;
    r = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      j = idx + 3'(k);
      if (mask[j]) r = j;
    end
    return r;
  endfunction

  assign mode_state = state_t'(mode);
  assign expire     = (cnt == CNT_W'(DWELL - 1));
  assign ch_first   = lowest_enabled(ch_mask);
  assign ch_next    = next_enabled(ch_idx, ch_mask);

  // Next-state computation. The state simply follows mode each edge; the
  // interesting part is what the indices, counter and outputs do depending on
  // where we came from. ctrl_out is built from the *next* index so that the
  // display changes on the same edge as the index itself.
  // came_from_manual remembers whether the last non-HOLD state was MANUAL,
  // which is what decides whether step is honoured while in HOLD.
  always_comb begin
    state_n = mode_state;
    ch_n    = ch_idx;
    reg_n   = reg_idx;
    cnt_n   = cnt;
    ctrl_n  = ctrl_out;
    tick_n  = 1'b0;
    kind_n  = scan_kind;
    cfm_n   = came_from_manual;
    case (mode_state)
      MANUAL: begin
        cnt_n  = '0;
        ctrl_n = sw_ctrl;
        cfm_n  = 1'b1;
      end
      SCAN_CH: begin
        kind_n = 1'b0;
        cfm_n  = 1'b0;
        if (state != SCAN_CH) begin
          // Entry edge: fresh dwell, no advance.
          cnt_n = '0;
          if (state == MANUAL) ch_n = ch_first;
        end else if (expire) begin
          // A coincident step is absorbed here: one advance, tick still fires.
          cnt_n  = '0;
          ch_n   = ch_next;
          tick_n = 1'b1;
        end else if (step) begin
          cnt_n = '0;
          ch_n  = ch_next;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
        ctrl_n = {3'b000, ch_n};
      end
      SCAN_REG: begin
        kind_n = 1'b1;
        cfm_n  = 1'b0;
        if (state != SCAN_REG) begin
          cnt_n = '0;
          if (state == MANUAL) reg_n = 5'd0;
        end else if (expire) begin
          cnt_n  = '0;
          reg_n  = reg_idx + 5'd1;
          tick_n = 1'b1;
        end else if (step) begin
          cnt_n = '0;
          reg_n = reg_idx + 5'd1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
        ctrl_n = {1'b1, reg_n};
      end
      HOLD: begin
        // Counter frozen. Stepping only makes sense after a scan; when HOLD
        // was reached straight from MANUAL the switch value stays on show.
        if (step && !came_from_manual) begin
          if (scan_kind) begin
            reg_n  = reg_idx + 5'd1;
            ctrl_n = {1'b1, reg_n};
          end else begin
            ch_n   = ch_next;
            ctrl_n = {3'b000, ch_n};
          end
        end
      end
      default: begin
      end
    endcase
  end

  // State and output registers. Reset is synchronous and overrides every
  // other input, including step and mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= MANUAL;
      ch_idx           <= 3'd0;
      reg_idx          <= 5'd0;
      cnt              <= '0;
      ctrl_out         <= 6'b000000;
      dwell_tick       <= 1'b0;
      scan_kind        <= 1'b0;
      came_from_manual <= 1'b1;
    end else begin
      state            <= state_n;
      ch_idx           <= ch_n;
      reg_idx          <= reg_n;
      cnt              <= cnt_n;
      ctrl_out         <= ctrl_n;
      dwell_tick       <= tick_n;
      scan_kind        <= kind_n;
      came_from_manual <= cfm_n;
    end
  end

endmodule

// File: tb/tb_seg7_scan_sched.sv
// tb_seg7_scan_sched
//   Self-checking bench for seg7_scan_sched with a short dwell (DWELL=4).
//   A table of per-cycle records {inputs, expected outputs} is built up front,
//   then each record is driven on the falling edge, its expectation queued,
//   and the queue popped and compared just after the following rising edge.
module tb_seg7_scan_sched;

  localparam int DWELL = 4;
  localparam int CNT_W = 3;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic [5:0] sw_ctrl;
  logic [7:0] ch_mask;
  logic       step;
  logic [5:0] ctrl_out;
  logic       dwell_tick;
  logic       scan_kind;

  typedef struct {
    logic       rst;
    logic [1:0] mode;
    logic [5:0] sw;
    logic [7:0] mask;
    logic       step;
    logic [5:0] exp_ctrl;
    logic       exp_tick;
    logic       exp_kind;
    logic       chk_tick;
    logic       chk_kind;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [5:0] ch3_pat [0:8];

  seg7_scan_sched #(
    .DWELL(DWELL),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .sw_ctrl    (sw_ctrl),
    .ch_mask    (ch_mask),
    .step       (step),
    .ctrl_out   (ctrl_out),
    .dwell_tick (dwell_tick),
    .scan_kind  (scan_kind)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void addVec(input logic r, input logic [1:0] m,
                                 input logic [5:0] sw, input logic [7:0] mk,
                                 input logic st, input logic [5:0] ec,
                                 input logic et, input logic ek,
                                 input logic ct, input logic ck);
    vec_t v;
    v.rst = r; v.mode = m; v.sw = sw; v.mask = mk; v.step = st;
    v.exp_ctrl = ec; v.exp_tick = et; v.exp_kind = ek;
    v.chk_tick = ct; v.chk_kind = ck;
    vecs.push_back(v);
  endfunction

  // Drive one record's inputs and queue its expected outputs.
  task automatic applyStimulus(input vec_t v);
    rst     = v.rst;
    mode    = v.mode;
    sw_ctrl = v.sw;
    ch_mask = v.mask;
    step    = v.step;
    exp_q.push_back(v);
  endtask

  // Pop the oldest expectation and compare it with what the DUT shows now.
  task automatic checkOutput(input int idx);
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL vec%0d scoreboard empty: got nothing, need an entry", idx);
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (ctrl_out !== e.exp_ctrl) begin
      failures++;
      $display("[TB] FAIL vec%0d ctrl_out: got %h, need %h", idx, ctrl_out, e.exp_ctrl);
    end
    if (e.chk_tick) begin
      checks++;
      if (dwell_tick !== e.exp_tick) begin
        failures++;
        $display("[TB] FAIL vec%0d dwell_tick: got %b, need %b", idx, dwell_tick, e.exp_tick);
      end
    end
    if (e.chk_kind) begin
      checks++;
      if (scan_kind !== e.exp_kind) begin
        failures++;
        $display("[TB] FAIL vec%0d scan_kind: got %b, need %b", idx, scan_kind, e.exp_kind);
      end
    end
  endtask

  initial begin
    rst = 1'b1; mode = 2'b00; sw_ctrl = 6'h25; ch_mask = 8'hFF; step = 1'b0;

    // Reset for two cycles, then the switches show up one cycle later.
    addVec(1, 2'b00, 6'h25, 8'hFF, 0, 6'h00, 0, 0, 1, 1);
    addVec(1, 2'b00, 6'h25, 8'hFF, 0, 6'h00, 0, 0, 1, 1);
    addVec(0, 2'b00, 6'h25, 8'hFF, 0, 6'h25, 0, 0, 1, 1);
    addVec(0, 2'b00, 6'h25, 8'hFF, 0, 6'h25, 0, 0, 1, 1);

    // Channel scan, all enabled: 0..7 then 0, four cycles each.
    for (int c = 0; c < 36; c++)
      addVec(0, 2'b01, 6'h25, 8'hFF, 0, 6'((c / 4) % 8),
             (c % 4 == 0) && (c > 0), 0, 1, 1);

    // Masked channel scan 2,7,2,7,2; mask switched mid-dwell to {4,5}
    // keeps channel 2 until the advance; then an empty mask forces 0.
    addVec(0, 2'b00, 6'h11, 8'h84, 0, 6'h11, 0, 0, 1, 0);
    ch3_pat[0] = 6'd2; ch3_pat[1] = 6'd7; ch3_pat[2] = 6'd2;
    ch3_pat[3] = 6'd7; ch3_pat[4] = 6'd2; ch3_pat[5] = 6'd4;
    ch3_pat[6] = 6'd5; ch3_pat[7] = 6'd0; ch3_pat[8] = 6'd0;
    for (int c = 0; c < 36; c++)
      addVec(0, 2'b01, 6'h11, (c < 18) ? 8'h84 : ((c < 28) ? 8'h30 : 8'h00), 0,
             ch3_pat[c / 4], (c % 4 == 0) && (c > 0), 0, c < 28, 1);

    // Register scan from MANUAL: 0x20..0x3F, wrap to 0x20, on to 0x23.
    addVec(0, 2'b00, 6'h0A, 8'hFF, 0, 6'h0A, 0, 0, 1, 0);
    for (int c = 0; c < 142; c++)
      addVec(0, 2'b10, 6'h0A, 8'hFF, 0, 6'h20 | 6'((c / 4) % 32),
             (c % 4 == 0) && (c > 0), 1, 1, 1);

    // HOLD freezes 0x23, step moves to 0x24, rescan gives a full dwell.
    for (int c = 0; c < 10; c++)
      addVec(0, 2'b11, 6'h0A, 8'hFF, 0, 6'h23, 0, 1, 1, 1);
    addVec(0, 2'b11, 6'h0A, 8'hFF, 1, 6'h24, 0, 1, 1, 1);
    addVec(0, 2'b11, 6'h0A, 8'hFF, 0, 6'h24, 0, 1, 1, 1);
    addVec(0, 2'b11, 6'h0A, 8'hFF, 0, 6'h24, 0, 1, 1, 1);
    for (int c = 0; c < 5; c++)
      addVec(0, 2'b10, 6'h0A, 8'hFF, 0, (c < 4) ? 6'h24 : 6'h25, c == 4, 1, 1, 1);

    // Step on the expiry cycle advances once with a tick; a lone step
    // advances without a tick and restarts the dwell.
    addVec(0, 2'b00, 6'h3F, 8'hFF, 0, 6'h3F, 0, 0, 1, 0);
    for (int c = 0; c < 4; c++)
      addVec(0, 2'b01, 6'h3F, 8'hFF, 0, 6'h00, 0, 0, 1, 1);
    addVec(0, 2'b01, 6'h3F, 8'hFF, 1, 6'h01, 1, 0, 1, 1);
    addVec(0, 2'b01, 6'h3F, 8'hFF, 1, 6'h02, 0, 0, 1, 1);
    for (int c = 0; c < 3; c++)
      addVec(0, 2'b01, 6'h3F, 8'hFF, 0, 6'h02, 0, 0, 1, 1);
    addVec(0, 2'b01, 6'h3F, 8'hFF, 0, 6'h03, 1, 0, 1, 1);
    addVec(0, 2'b01, 6'h3F, 8'hFF, 0, 6'h03, 0, 0, 1, 1);

    // Reset mid-scan wins over mode and step; afterwards HOLD straight from
    // MANUAL ignores step, and step in MANUAL is ignored too.
    addVec(1, 2'b01, 6'h3F, 8'hFF, 1, 6'h00, 0, 0, 1, 1);
    addVec(0, 2'b11, 6'h3F, 8'hFF, 1, 6'h00, 0, 0, 1, 1);
    addVec(0, 2'b00, 6'h07, 8'hFF, 1, 6'h07, 0, 0, 1, 1);
    addVec(0, 2'b11, 6'h15, 8'hFF, 1, 6'h07, 0, 0, 1, 1);
    addVec(0, 2'b11, 6'h15, 8'hFF, 0, 6'h07, 0, 0, 1, 1);
    addVec(0, 2'b01, 6'h15, 8'hFF, 0, 6'h00, 0, 0, 1, 1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput(i);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
